// File: rtl/ffdemux_deser.sv
// Registered 1-to-N serial demux/deserializer for the TDC datapath.
// A frame start steers successive bits into lanes, then publishes the word.
module ffdemux_deser #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 start,
   input  logic                 D,
   output logic [N-1:0]         Z,
   output logic [$clog2(N)-1:0] sel,
   output logic [N-1:0]         Q,
   output logic                 valid,
   output logic                 busy,
   output logic                 err
);

   localparam int W = $clog2(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state, state_nx;
   logic [W-1:0]   cnt, cnt_nx;
   logic [N-1:0]   z_nx, q_nx;
   logic           valid_nx, err_nx;

   function automatic logic [W-1:0] idx(input logic [W-1:0] c);
      return MSB_FIRST ? LAST - c : c;
   endfunction

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      z_nx     = Z;
      q_nx     = Q;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (en && start) begin
               z_nx[idx('0)] = D;
               cnt_nx        = W'(1);
               state_nx      = SHIFT;
            end
         end
         SHIFT: begin
            if (en) begin
               if (start) begin
                  // resync: the partial word is dropped, never published
                  err_nx        = 1'b1;
                  z_nx[idx('0)] = D;
                  cnt_nx        = W'(1);
               end else begin
                  z_nx[idx(cnt)] = D;
                  if (cnt == LAST) begin
                     q_nx     = z_nx;
                     valid_nx = 1'b1;
                     cnt_nx   = '0;
                     state_nx = IDLE;
                  end else begin
                     cnt_nx = cnt + W'(1);
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         cnt   <= '0;
         Z     <= '0;
         Q     <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         Z     <= z_nx;
         Q     <= q_nx;
         valid <= valid_nx;
         err   <= err_nx;
      end
   end

   assign busy = (state == SHIFT);
   assign sel  = busy ? idx(cnt) : idx('0);

endmodule

// File: tb/tb_ffdemux_deser.sv
// Bench for ffdemux_deser: table of frames plus hand-written corner sequences.
// MSB-first and LSB-first instances share one input stream.
module tb_ffdemux_deser;

   logic       clk, clr, en, start, D;
   logic [7:0] z_m, q_o_m, z_l, q_o_l;
   logic [2:0] sel_m, sel_l;
   logic       valid_m, busy_m, err_m;
   logic       valid_l, busy_l, err_l;

   ffdemux_deser #(.N(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .clr(clr), .en(en), .start(start), .D(D),
      .Z(z_m), .sel(sel_m), .Q(q_o_m),
      .valid(valid_m), .busy(busy_m), .err(err_m)
   );

   ffdemux_deser #(.N(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .clr(clr), .en(en), .start(start), .D(D),
      .Z(z_l), .sel(sel_l), .Q(q_o_l),
      .valid(valid_l), .busy(busy_l), .err(err_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] w;
      int         sa;
      int         sl;
      logic [7:0] em;
      logic [7:0] el;
      int         lat;
   } vec_t;

   vec_t       tbl[5];
   logic [7:0] sb_m[$];
   logic [7:0] sb_l[$];
   int         total, bad, cyc, errs;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] q,
                          inout logic [7:0] sb[$]);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: unexpected valid, Q=%0h", nm, q);
      end else begin
         chk(nm, q, sb.pop_front());
      end
   endtask

   task automatic step(input logic c, input logic e, input logic s,
                       input logic d);
      clr = c; en = e; start = s; D = d;
      @(posedge clk);
      #1;
      cyc++;
      if (valid_m) pop_chk("q_msb", q_o_m, sb_m);
      if (valid_l) pop_chk("q_lsb", q_o_l, sb_l);
      if (err_m) errs++;
   endtask

   task automatic frame(input logic [7:0] w, input int sa, input int sl,
                        input logic [7:0] em, input logic [7:0] el,
                        input int lat, input logic xerr, output int vc);
      int         c0, bz;
      logic       vbad;
      logic [7:0] zs;
      sb_m.push_back(em);
      sb_l.push_back(el);
      bz = 0; vbad = 1'b0; c0 = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, i == 0, w[7-i]);
         if (i == 0) begin
            c0 = cyc;
            chk("err_on_start", err_m, xerr);
            chk("sel_after_start", sel_m, 6);
            chk("sel_lsb_after_start", sel_l, 1);
         end
         if (busy_m) bz++;
         if (valid_m !== (i == 7)) vbad = 1'b1;
         if (i + 1 == sa) begin
            for (int k = 0; k < sl; k++) begin
               zs = z_m;
               step(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
               if (busy_m) bz++;
               if (valid_m) vbad = 1'b1;
               chk("stall_z", z_m, zs);
            end
         end
      end
      vc = cyc;
      chk("latency", cyc - c0 + 1, lat);
      chk("busy_cycles", bz, lat - 1);
      chk("valid_once", vbad, 0);
   endtask

   initial begin
      int         v1, v2;
      logic [7:0] zs;
      total = 0; bad = 0; cyc = 0; errs = 0;
      clr = 1'b1; en = 1'b0; start = 1'b0; D = 1'b0;

      tbl[0] = '{8'hB2, 0, 0, 8'hB2, 8'h4D, 8};
      tbl[1] = '{8'hB2, 3, 3, 8'hB2, 8'h4D, 11};
      tbl[2] = '{8'hFF, 0, 0, 8'hFF, 8'hFF, 8};
      tbl[3] = '{8'h01, 0, 0, 8'h01, 8'h80, 8};
      tbl[4] = '{8'h5A, 7, 1, 8'h5A, 8'h5A, 9};

      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("rst_z", z_m, 0);
      chk("rst_q", q_o_m, 0);
      chk("rst_valid", valid_m, 0);
      chk("rst_err", err_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_sel", sel_m, 7);
      chk("rst_sel_lsb", sel_l, 0);

      for (int t = 0; t < 5; t++) begin
         zs = z_m;
         step(1'b0, 1'b1, 1'b0, 1'b1);
         chk("idle_hold_z", z_m, zs);
         chk("idle_busy", busy_m, 0);
         frame(tbl[t].w, tbl[t].sa, tbl[t].sl, tbl[t].em, tbl[t].el,
               tbl[t].lat, 1'b0, v1);
         chk("q_hold", q_o_m, tbl[t].em);
      end

      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      frame(8'h5A, 0, 0, 8'h5A, 8'h5A, 8, 1'b1, v1);

      frame(8'hB2, 0, 0, 8'hB2, 8'h4D, 8, 1'b0, v1);
      frame(8'h4D, 0, 0, 8'h4D, 8'hB2, 8, 1'b0, v2);
      chk("b2b_gap", v2 - v1, 8);

      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_busy", busy_m, 0);
      chk("clr_q", q_o_m, 0);
      chk("clr_z", z_m, 0);
      chk("clr_valid", valid_m, 0);
      chk("clr_err", err_m, 0);
      chk("clr_sel", sel_m, 7);
      frame(8'hE1, 0, 0, 8'hE1, 8'h87, 8, 1'b0, v1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      chk("err_total", errs, 1);
      chk("sb_msb_empty", sb_m.size(), 0);
      chk("sb_lsb_empty", sb_l.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ffdemux_deser.md
Name: ffdemux_deser

Overview:
- Registered 1-to-N demultiplexer and deserializer: the receive end of a serialized mux-plus-flip-flop path in the TDC datapath.
- Takes the 1-bit registered stream and, under a frame `start`, steers successive bits into N registered lane outputs.
- Publishes the assembled word with a one-cycle `valid` pulse for the TDC readout logic.
- Flags resynchronisation errors when a new frame starts before the current one completes.

Parameters:
- N, 8, number of lanes = word width; legal range N >= 2.
- MSB_FIRST, 1, 1: the first bit of a frame lands in lane N-1; 0: the first bit lands in lane 0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-high reset (clear).
- en  input  1  sample enable; D is consumed only on cycles with en=1.
- start  input  1  frame sync; marks D as bit 0 of a new frame (effective only with en=1).
- D  input  1  serial data bit.
- Z  output  N  demux lane registers; lane idx(cnt) is written with D on each consumed bit.
- sel  output  clog2(N)  lane index that the next consumed bit will write.
- Q  output  N  last completed word.
- valid  output  1  one-cycle pulse; Q was updated on this edge.
- busy  output  1  frame in progress (state SHIFT).
- err  output  1  one-cycle pulse; frame aborted by start.

Behaviour:
- Reset:
  - When clr=1 at an edge: Z=0, Q=0, valid=0, err=0, busy=0, cnt=0, state=IDLE.
  - sel = idx(0), i.e. N-1 when MSB_FIRST=1, 0 when MSB_FIRST=0.
  - clr overrides en, start and every other event.
  - A clr mid-frame discards the partial frame without a valid or err pulse.
- Bit counter: cnt counts 0..N-1. idx(cnt) = N-1-cnt if MSB_FIRST else cnt. sel = idx(cnt) in SHIFT, idx(0) in IDLE.
- "Consume" means en=1 at the edge. On every consumed bit, Z[idx] <= D; all other lanes hold.
- Z is not cleared between frames.
- valid and err default to 0 on every edge unless set below.
- FSM, IDLE:
  - start&en: Z[idx(0)] <= D, cnt <= 1, go to SHIFT.
  - Otherwise hold, including en=1 without start.
- FSM, SHIFT:
  - en=0: stall; all state holds.
  - en=1 & start: resync. err <= 1; Z[idx(0)] <= D; cnt <= 1; stay in SHIFT. The partial word is never published.
  - en=1 & !start & cnt<N-1: Z[idx(cnt)] <= D; cnt <= cnt+1.
  - en=1 & !start & cnt==N-1 (last bit): Z[idx(N-1)] <= D; Q <= Z with lane idx(N-1) replaced by D; valid <= 1; cnt <= 0; go to IDLE.
- Latency:
  - Q and valid update on the same edge that samples the last bit.
  - A stall-free frame spans N consecutive edges from its start edge.
  - busy is high for N-1 cycles, between the start edge and the last-bit edge.
- Back-to-back frames:
  - A start on the cycle immediately after the last-bit edge begins a new frame.
  - valid pulses are therefore N cycles apart.
- Q holds its value until the next completed frame.
- No internal state counts past N-1.

Test Plan:
- Reset: clr=1 for 2 cycles while start/en/D toggle -> Z=0, Q=0, valid=0, err=0, busy=0, sel=7 (N=8, MSB_FIRST=1).
- Basic frame (N=8, MSB_FIRST=1): start+en with D=1,0,1,1,0,0,1,0 on 8 consecutive cycles -> Q=8'hB2; valid high exactly 1 cycle, on the 8th edge; busy high 7 cycles; err=0.
- Stalls: same bit sequence with en=0 for 3 cycles after bit 3 -> Q=8'hB2; valid 3 cycles later than in the basic-frame case; Z unchanged during the stall.
- Resync: 4 bits of a frame, then start+en with bits of 8'h5A -> err pulse on the start edge; single valid pulse with Q=8'h5A; the aborted word never appears.
- Back-to-back and LSB-first:
  - Frames 8'hB2 then 8'h4D, second start on the cycle after the last bit -> valid pulses exactly 8 cycles apart, Q=B2 then 4D.
  - With MSB_FIRST=0, D=1,0,1,1,0,0,1,0 -> Q=8'h4D.
- Mid-frame clear: clr=1 after 5 bits -> busy=0 and Q=0 next cycle, no valid or err pulse; a following full frame completes normally.
